// File: rtl/pov_pkg.sv
// Shared types, mode encodings, width helpers and the brightness scaler
// used by the POV frame mapper and its sequencer.
package pov_pkg;

   localparam int DEF_LED_COUNT  = 52;
   localparam int DEF_TEX_WIDTH  = 64;
   localparam int DEF_THETA_BITS = 6;
   localparam int DEF_NUM_FRAMES = 30;
   localparam int DEF_CHANNELS   = 2;

   typedef enum logic [1:0] {
      MODE_LOOP     = 2'b00,
      MODE_ONESHOT  = 2'b01,
      MODE_PINGPONG = 2'b10,
      MODE_HOLD     = 2'b11
   } mode_e;

   typedef struct packed {
      logic [7:0] g;
      logic [7:0] r;
      logic [7:0] b;
   } pixel_t;

   function automatic int min_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int frame_size(input int leds, input int cols);
      return leds * cols;
   endfunction

   function automatic int px_width(input int leds);
      return min_width(leds);
   endfunction

   function automatic int fidx_width(input int frames);
      return min_width(frames);
   endfunction

   function automatic int rom_aw(input int leds, input int cols, input int frames);
      return min_width(frame_size(leds, cols) * frames);
   endfunction

   // Multiplying by brightness+1 makes 255 an exact passthrough and 0 a blackout.
   function automatic logic [7:0] scale8(input logic [7:0] v, input logic [7:0] b);
      logic [16:0] prod;
      prod = 17'(v) * (17'(b) + 17'd1);
      return 8'(prod >> 8);
   endfunction

   function automatic pixel_t scale_pixel(input pixel_t p, input logic [7:0] b);
      pixel_t o;
      o.g = scale8(p.g, b);
      o.r = scale8(p.r, b);
      o.b = scale8(p.b, b);
      return o;
   endfunction

endpackage

// File: rtl/pov_frame_mapper_if.sv
// Texture ROM port plus per-channel LED request and pixel return bus.
interface pov_frame_mapper_if #(
   parameter int CHANNELS = 2,
   parameter int PXW      = 6,
   parameter int ROM_AW   = 17
);

   logic [CHANNELS*PXW-1:0] px_num;
   logic [ROM_AW-1:0]       rom_addr;
   logic [23:0]             rom_data;
   logic [CHANNELS*24-1:0]  pix_data;
   logic [CHANNELS-1:0]     pix_valid;

   modport master (
      input  px_num,
      input  rom_data,
      output rom_addr,
      output pix_data,
      output pix_valid
   );

   modport slave (
      output px_num,
      output rom_data,
      input  rom_addr,
      input  pix_data,
      input  pix_valid
   );

endinterface

// File: rtl/pov_frame_sequencer.sv
// Animation frame sequencer: frame timer, step/tick advance and the four
// playback modes, including the ping-pong direction state.
module pov_frame_sequencer import pov_pkg::*; #(
   parameter int NUM_FRAMES = DEF_NUM_FRAMES,
   parameter int FIDX_W     = fidx_width(NUM_FRAMES)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       frame_period,
   input  logic [1:0]        mode,
   input  logic              play,
   input  logic              step,
   output logic [FIDX_W-1:0] frame_idx,
   output logic              done
);

   typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

   localparam logic [FIDX_W-1:0] LAST    = FIDX_W'(NUM_FRAMES - 1);
   localparam logic [FIDX_W-1:0] IDX_ONE = FIDX_W'(1);

   mode_e             cur_mode;
   dir_e              dir, dir_nxt;
   logic [31:0]       timer, timer_nxt;
   logic [FIDX_W-1:0] idx_nxt;
   logic              tick, advance;

   assign cur_mode = mode_e'(mode);
   assign done     = (cur_mode == MODE_ONESHOT) && (frame_idx == LAST);

   always_ff @(posedge clk) begin
      if (!reset) begin
         timer     <= '0;
         frame_idx <= '0;
         dir       <= DIR_UP;
      end else begin
         timer     <= timer_nxt;
         frame_idx <= idx_nxt;
         dir       <= dir_nxt;
      end
   end

   // Outside ping-pong the direction is parked at UP so entering mode 10 always climbs first.
   always_comb begin
      tick      = 1'b0;
      timer_nxt = timer;
      idx_nxt   = frame_idx;
      dir_nxt   = (cur_mode == MODE_PINGPONG) ? dir : DIR_UP;
      if (play && (frame_period != 32'd0)) begin
         if (timer >= frame_period - 32'd1) begin
            tick      = 1'b1;
            timer_nxt = '0;
         end else begin
            timer_nxt = timer + 32'd1;
         end
      end
      advance = tick || (step && !play);
      if (advance && (NUM_FRAMES > 1)) begin
         unique case (cur_mode)
            MODE_LOOP:     idx_nxt = (frame_idx >= LAST) ? '0 : frame_idx + IDX_ONE;
            MODE_ONESHOT:  idx_nxt = (frame_idx >= LAST) ? LAST : frame_idx + IDX_ONE;
            MODE_PINGPONG: begin
               if (dir == DIR_UP) begin
                  if (frame_idx >= LAST) begin
                     idx_nxt = frame_idx - IDX_ONE;
                     dir_nxt = DIR_DOWN;
                  end else begin
                     idx_nxt = frame_idx + IDX_ONE;
                  end
               end else begin
                  if (frame_idx == '0) begin
                     idx_nxt = IDX_ONE;
                     dir_nxt = DIR_UP;
                  end else begin
                     idx_nxt = frame_idx - IDX_ONE;
                  end
               end
            end
            MODE_HOLD:     idx_nxt = frame_idx;
         endcase
      end
   end

endmodule

// File: rtl/pov_frame_mapper.sv
// Multi-arm POV texture mapper: round-robin ROM arbitration, address
// generation with revolution-synchronous frame swap, and brightness scaling.
module pov_frame_mapper import pov_pkg::*; #(
   parameter int LED_COUNT   = DEF_LED_COUNT,
   parameter int TEX_WIDTH   = DEF_TEX_WIDTH,
   parameter int THETA_BITS  = DEF_THETA_BITS,
   parameter int NUM_FRAMES  = DEF_NUM_FRAMES,
   parameter int CHANNELS    = DEF_CHANNELS,
   parameter int ROM_LATENCY = 1,
   parameter int SYNC_SWAP   = 1,
   parameter int PXW         = px_width(LED_COUNT),
   parameter int FIDX_W      = fidx_width(NUM_FRAMES),
   parameter int ROM_AW      = rom_aw(LED_COUNT, TEX_WIDTH, NUM_FRAMES)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [THETA_BITS-1:0] theta,
   input  logic [THETA_BITS-1:0] theta_offset,
   input  logic [31:0]           frame_period,
   input  logic [1:0]            mode,
   input  logic                  play,
   input  logic                  step,
   input  logic [7:0]            brightness,
   pov_frame_mapper_if.master    bus,
   output logic [FIDX_W-1:0]     frame_idx,
   output logic                  done
);

   localparam int FRAME_SIZE = frame_size(LED_COUNT, TEX_WIDTH);
   localparam int CSW        = min_width(CHANNELS);
   localparam int COL_STEP   = TEX_WIDTH / CHANNELS;

   logic [CSW-1:0]        ch_sel;
   logic [THETA_BITS-1:0] prev_theta, col;
   logic [FIDX_W-1:0]     disp_idx, disp_eff;
   logic [PXW-1:0]        px_raw, px_clamped;
   logic [ROM_AW-1:0]     addr;
   logic                  wrap;
   logic [CSW-1:0]        tag_pipe [ROM_LATENCY+1];
   logic [ROM_LATENCY:0]  vld_pipe;

   pov_frame_sequencer #(
      .NUM_FRAMES (NUM_FRAMES),
      .FIDX_W     (FIDX_W)
   ) u_seq (
      .clk          (clk),
      .reset        (reset),
      .frame_period (frame_period),
      .mode         (mode),
      .play         (play),
      .step         (step),
      .frame_idx    (frame_idx),
      .done         (done)
   );

   // The wrap sample itself already addresses the new frame.
   assign wrap     = theta < prev_theta;
   assign disp_eff = (SYNC_SWAP != 0) ? (wrap ? frame_idx : disp_idx) : frame_idx;

   always_comb begin
      px_raw     = bus.px_num[ch_sel*PXW +: PXW];
      px_clamped = (32'(px_raw) >= 32'(LED_COUNT)) ? PXW'(LED_COUNT - 1) : px_raw;
      col        = theta + theta_offset + THETA_BITS'(32'(ch_sel) * COL_STEP);
      addr       = ROM_AW'(disp_eff) * ROM_AW'(FRAME_SIZE)
                 + ROM_AW'(px_clamped) * ROM_AW'(TEX_WIDTH)
                 + ROM_AW'(col);
   end

   // Channel tag and valid travel alongside the ROM read so returns land in the right slice.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ch_sel        <= '0;
         prev_theta    <= '0;
         disp_idx      <= '0;
         bus.rom_addr  <= '0;
         vld_pipe      <= '0;
         bus.pix_data  <= '0;
         bus.pix_valid <= '0;
         for (int i = 0; i <= ROM_LATENCY; i++) tag_pipe[i] <= '0;
      end else begin
         ch_sel       <= (ch_sel == CSW'(CHANNELS - 1)) ? '0 : ch_sel + CSW'(1);
         prev_theta   <= theta;
         if ((SYNC_SWAP != 0) && wrap) disp_idx <= frame_idx;
         bus.rom_addr <= addr;
         vld_pipe[0]  <= 1'b1;
         tag_pipe[0]  <= ch_sel;
         for (int i = 1; i <= ROM_LATENCY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            tag_pipe[i] <= tag_pipe[i-1];
         end
         bus.pix_valid <= '0;
         if (vld_pipe[ROM_LATENCY]) begin
            bus.pix_valid[tag_pipe[ROM_LATENCY]] <= 1'b1;
            bus.pix_data[tag_pipe[ROM_LATENCY]*24 +: 24] <= scale_pixel(pixel_t'(bus.rom_data), brightness);
         end
      end
   end

endmodule

// File: tb/tb_pov_frame_mapper.sv
// Self-checking bench for pov_frame_mapper: directed literal checks plus a
// randomized run compared every cycle against a behavioural model.
module tb_pov_frame_mapper;

   localparam int LED_COUNT   = 52;
   localparam int TEX_WIDTH   = 64;
   localparam int THETA_BITS  = 6;
   localparam int NUM_FRAMES  = 3;
   localparam int CHANNELS    = 2;
   localparam int ROM_LATENCY = 1;
   localparam int SYNC_SWAP   = 1;
   localparam int PXW         = 6;
   localparam int FIDX_W      = 2;
   localparam int ROM_AW      = 14;
   localparam int FRAME_SIZE  = LED_COUNT * TEX_WIDTH;

   typedef struct {
      int due;
      int ch;
      int addr;
   } req_t;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [THETA_BITS-1:0] theta, theta_offset;
   logic [31:0]           frame_period;
   logic [1:0]            mode;
   logic                  play, step;
   logic [7:0]            brightness;
   logic [FIDX_W-1:0]     frame_idx;
   logic                  done;
   logic                  rom_force;

   int checks   = 0;
   int failures = 0;

   pov_frame_mapper_if #(.CHANNELS(CHANNELS), .PXW(PXW), .ROM_AW(ROM_AW)) bus ();

   pov_frame_mapper #(
      .LED_COUNT   (LED_COUNT),
      .TEX_WIDTH   (TEX_WIDTH),
      .THETA_BITS  (THETA_BITS),
      .NUM_FRAMES  (NUM_FRAMES),
      .CHANNELS    (CHANNELS),
      .ROM_LATENCY (ROM_LATENCY),
      .SYNC_SWAP   (SYNC_SWAP)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .theta        (theta),
      .theta_offset (theta_offset),
      .frame_period (frame_period),
      .mode         (mode),
      .play         (play),
      .step         (step),
      .brightness   (brightness),
      .bus          (bus),
      .frame_idx    (frame_idx),
      .done         (done)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] rom_word(input int a);
      logic [31:0] h;
      h = 32'(a) * 32'h9E3779B1;
      return 24'(h ^ (h >> 15));
   endfunction

   function automatic logic [23:0] rom_value(input int a);
      return rom_force ? 24'hFF8000 : rom_word(a);
   endfunction

   function automatic logic [23:0] scale_model(input logic [23:0] v, input int b);
      int g, r, bl;
      g  = (int'(v[23:16]) * (b + 1)) / 256;
      r  = (int'(v[15:8])  * (b + 1)) / 256;
      bl = (int'(v[7:0])   * (b + 1)) / 256;
      return {8'(g), 8'(r), 8'(bl)};
   endfunction

   // Texture ROM with one cycle of read latency.
   always @(posedge clk) bus.rom_data <= rom_value(int'(bus.rom_addr));

   task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("[TB] FAIL %s t=%0t got=%0h want=%0h", name, $time, got, want);
      end
   endtask

   task automatic apply_stimulus(input logic rst, input int th, input int off, input int fp,
                                 input int md, input logic pl, input int br, input int p0, input int p1);
      reset        = rst;
      theta        = THETA_BITS'(th);
      theta_offset = THETA_BITS'(off);
      frame_period = 32'(fp);
      mode         = 2'(md);
      play         = pl;
      step         = 1'b0;
      brightness   = 8'(br);
      bus.px_num   = {PXW'(p1), PXW'(p0)};
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Behavioural model, advanced on every rising edge from the inputs held since the last falling edge.
   int          cyc = 0;
   bit          model_ok = 1'b0;
   int          m_frame, m_dir, m_disp, m_prev_theta, m_ch, m_prev_mode;
   longint      m_timer;
   int          exp_addr;
   logic [1:0]  exp_valid;
   logic [23:0] exp_pix [CHANNELS];
   req_t        pend [$];
   req_t        rq;
   int          mp, mcol, maddr;
   bit          madv;

   always @(posedge clk) begin
      cyc++;
      if (!reset) begin
         model_ok     = 1'b1;
         m_frame      = 0;
         m_dir        = 1;
         m_timer      = 0;
         m_disp       = 0;
         m_prev_theta = 0;
         m_ch         = 0;
         m_prev_mode  = int'(mode);
         pend.delete();
         exp_addr     = 0;
         exp_valid    = '0;
         for (int c = 0; c < CHANNELS; c++) exp_pix[c] = '0;
      end else begin
         exp_valid = '0;
         while (pend.size() > 0 && pend[0].due == cyc) begin
            rq = pend.pop_front();
            exp_valid[rq.ch] = 1'b1;
            exp_pix[rq.ch]   = scale_model(rom_value(rq.addr), int'(brightness));
         end
         if (SYNC_SWAP != 0) begin
            if (int'(theta) < m_prev_theta) m_disp = m_frame;
         end else begin
            m_disp = m_frame;
         end
         m_prev_theta = int'(theta);
         mp    = int'(bus.px_num[m_ch*PXW +: PXW]);
         if (mp >= LED_COUNT) mp = LED_COUNT - 1;
         mcol  = (int'(theta) + int'(theta_offset) + m_ch * (TEX_WIDTH / CHANNELS)) % TEX_WIDTH;
         maddr = m_disp * FRAME_SIZE + mp * TEX_WIDTH + mcol;
         exp_addr = maddr;
         pend.push_back('{due: cyc + ROM_LATENCY + 1, ch: m_ch, addr: maddr});
         m_ch = (m_ch + 1) % CHANNELS;

         madv = 1'b0;
         if (play && frame_period != 0) begin
            if (m_timer >= longint'(frame_period) - 1) begin
               madv    = 1'b1;
               m_timer = 0;
            end else begin
               m_timer++;
            end
         end
         if (step && !play) madv = 1'b1;
         if (int'(mode) == 2 && m_prev_mode != 2) m_dir = 1;
         if (madv && NUM_FRAMES > 1) begin
            case (int'(mode))
               0: m_frame = (m_frame + 1) % NUM_FRAMES;
               1: if (m_frame < NUM_FRAMES - 1) m_frame++;
               2: begin
                  if (m_frame + m_dir > NUM_FRAMES - 1 || m_frame + m_dir < 0) m_dir = -m_dir;
                  m_frame += m_dir;
               end
               default: ;
            endcase
         end
         m_prev_mode = int'(mode);
      end
   end

   always @(posedge clk) begin
      #2;
      if (model_ok) begin
         check_output("rom_addr",  64'(bus.rom_addr),        64'(exp_addr));
         check_output("pix_valid", 64'(bus.pix_valid),       64'(exp_valid));
         check_output("pix_data0", 64'(bus.pix_data[23:0]),  64'(exp_pix[0]));
         check_output("pix_data1", 64'(bus.pix_data[47:24]), 64'(exp_pix[1]));
         check_output("frame_idx", 64'(frame_idx),           64'(m_frame));
         check_output("done",      64'(done), 64'((int'(mode) == 1) && (m_frame == NUM_FRAMES - 1)));
      end
   end

   initial begin
      int seq_os [5];
      int seq_pp [5];
      int r;
      seq_os = '{1, 2, 2, 2, 2};
      seq_pp = '{1, 2, 1, 0, 1};
      rom_force = 1'b0;
      apply_stimulus(1'b0, 0, 0, 0, 0, 1'b0, 255, 0, 0);
      wait_neg(2);
      check_output("rst_frame", 64'(frame_idx), 64'd0);
      check_output("rst_addr",  64'(bus.rom_addr), 64'd0);
      check_output("rst_valid", 64'(bus.pix_valid), 64'd0);
      check_output("rst_pix",   64'(bus.pix_data), 64'd0);
      check_output("rst_done",  64'(done), 64'd0);

      apply_stimulus(1'b1, 0, 0, 4, 0, 1'b1, 255, 0, 0);
      wait_neg(4); check_output("loop_f1", 64'(frame_idx), 64'd1);
      wait_neg(4); check_output("loop_f2", 64'(frame_idx), 64'd2);
      wait_neg(4); check_output("loop_f0", 64'(frame_idx), 64'd0);
      check_output("loop_done", 64'(done), 64'd0);

      apply_stimulus(1'b0, 0, 0, 4, 1, 1'b0, 255, 0, 0);
      wait_neg(1);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step = 1'b1; wait_neg(1);
         step = 1'b0; wait_neg(1);
         check_output("os_frame", 64'(frame_idx), 64'(seq_os[i]));
         check_output("os_done",  64'(done), 64'(seq_os[i] == 2));
      end
      play = 1'b1; frame_period = 0; step = 1'b1; wait_neg(1);
      step = 1'b0;
      check_output("os_step_play", 64'(frame_idx), 64'd2);

      apply_stimulus(1'b0, 0, 0, 2, 2, 1'b1, 255, 0, 0);
      wait_neg(1);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wait_neg(2);
         check_output("pp_frame", 64'(frame_idx), 64'(seq_pp[i]));
      end

      apply_stimulus(1'b0, 5, 0, 0, 3, 1'b0, 255, 3, 10);
      wait_neg(1);
      reset = 1'b1;
      wait_neg(1); check_output("addr_ch0", 64'(bus.rom_addr), 64'd197);
      wait_neg(1); check_output("addr_ch1", 64'(bus.rom_addr), 64'd677);
      wait_neg(1);
      check_output("lat_valid0", 64'(bus.pix_valid), 64'b01);
      check_output("lat_pix0",   64'(bus.pix_data[23:0]), 64'(rom_word(197)));
      bus.px_num = {PXW'(63), PXW'(52)};
      wait_neg(1);
      check_output("lat_valid1", 64'(bus.pix_valid), 64'b10);
      check_output("lat_pix1",   64'(bus.pix_data[47:24]), 64'(rom_word(677)));
      check_output("clamp_ch1",  64'(bus.rom_addr), 64'd3301);
      wait_neg(1); check_output("clamp_ch0", 64'(bus.rom_addr), 64'd3269);

      apply_stimulus(1'b0, 60, 0, 0, 0, 1'b0, 255, 0, 0);
      wait_neg(1);
      reset = 1'b1;
      wait_neg(1); check_output("swap_60", 64'(bus.rom_addr), 64'd60);
      theta = 61; step = 1'b1;
      wait_neg(1); check_output("swap_61", 64'(bus.rom_addr), 64'd29);
      check_output("swap_fidx", 64'(frame_idx), 64'd1);
      theta = 62; step = 1'b0;
      wait_neg(1); check_output("swap_62", 64'(bus.rom_addr), 64'd62);
      theta = 63;
      wait_neg(1); check_output("swap_63", 64'(bus.rom_addr), 64'd31);
      theta = 0;
      wait_neg(1); check_output("swap_0", 64'(bus.rom_addr), 64'd3328);
      theta = 1;
      wait_neg(1); check_output("swap_1", 64'(bus.rom_addr), 64'd3361);

      apply_stimulus(1'b0, 10, 0, 0, 3, 1'b0, 127, 1, 2);
      rom_force = 1'b1;
      wait_neg(1);
      reset = 1'b1;
      wait_neg(3);
      check_output("bright_valid", 64'(bus.pix_valid), 64'b01);
      check_output("bright_pix",   64'(bus.pix_data[23:0]), 64'h7F4000);
      reset = 1'b0;
      wait_neg(1);
      check_output("mid_rst_valid", 64'(bus.pix_valid), 64'd0);
      check_output("mid_rst_pix",   64'(bus.pix_data), 64'd0);
      check_output("mid_rst_addr",  64'(bus.rom_addr), 64'd0);
      rom_force = 1'b0;
      wait_neg(1);
      reset = 1'b1;
      wait_neg(1); check_output("no_stale1", 64'(bus.pix_valid), 64'd0);
      wait_neg(1); check_output("no_stale2", 64'(bus.pix_valid), 64'd0);
      wait_neg(1); check_output("first_valid", 64'(bus.pix_valid), 64'b01);

      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 199) != 0);
         r = $urandom_range(0, 9);
         if (r < 8) theta = theta + 1'b1;
         else if (r == 9) theta = THETA_BITS'($urandom);
         if ($urandom_range(0, 29) == 0) theta_offset = THETA_BITS'($urandom);
         if ($urandom_range(0, 19) == 0) frame_period = 32'($urandom_range(0, 5));
         if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
         if ($urandom_range(0, 9) == 0) play = ~play;
         step = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 9) == 0) brightness = 8'($urandom);
         bus.px_num = {PXW'($urandom_range(0, 63)), PXW'($urandom_range(0, 63))};
      end
      wait_neg(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pov_frame_mapper.md
Name: pov_frame_mapper

Overview:
Multi-arm POV texture mapper. Sequences animation frames at a programmable rate with loop, one-shot, ping-pong or hold playback. Translates per-channel LED indices plus rotor angle into texture-ROM addresses over one shared time-multiplexed ROM port. Returns brightness-scaled 24-bit pixels to up to CHANNELS neopixel controllers; sits between the angle generator, texture ROM and strip drivers.

Parameters:
LED_COUNT, 52, LEDs per arm
TEX_WIDTH, 64, texture columns per revolution (power of 2)
THETA_BITS, 6, angle width; must equal log2(TEX_WIDTH)
NUM_FRAMES, 30, frames stored contiguously in ROM, frame f at f*FRAME_SIZE
CHANNELS, 2, arms/strips served (1..8)
ROM_LATENCY, 1, cycles from rom_addr to valid rom_data
SYNC_SWAP, 1, 1 = displayed frame changes only at revolution wrap; 0 = immediate

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
theta  in  THETA_BITS  current rotor angle
theta_offset  in  THETA_BITS  global column rotation
frame_period  in  32  clk cycles per frame; 0 = timer stopped
mode  in  2  00 loop, 01 one-shot, 10 ping-pong, 11 hold
play  in  1  1 = timer-driven advance
step  in  1  single-cycle pulse; advances one frame when play=0
brightness  in  8  global scale, 255 = unity
px_num  in  CHANNELS*PXW  per-channel requested LED index, PXW=clog2(LED_COUNT)
rom_addr  out  ROM_AW  texture ROM address, ROM_AW=clog2(FRAME_SIZE*NUM_FRAMES)
rom_data  in  24  ROM read data
pix_data  out  CHANNELS*24  per-channel scaled pixel
pix_valid  out  CHANNELS  one-cycle strobe per updated pix_data slice
frame_idx  out  FIDX_W  sequencer frame index
done  out  1  one-shot finished

Behaviour:
- Reset (reset=0 at edge): pix_data, pix_valid, rom_addr, frame_idx, done, display index, timer, direction, ch_sel all 0; in-flight reads discarded.
- Timer: counts while play=1 and frame_period!=0; at timer>=frame_period-1 tick and clear. Shrinking frame_period below timer ticks next cycle.
- Advance event = tick, or step while play=0; step while play=1 ignored.
- Loop: last→0. One-shot: stops at NUM_FRAMES-1; done=1 level while mode=01 and frame_idx=last. Ping-pong: direction flips at both ends (…,last-1,last,last-1,…,0,1…). Hold: no advance. NUM_FRAMES=1: index stays 0 in all modes.
- Mode change takes effect on the next advance; ping-pong direction resets to up on entering mode 10.
- Display index: SYNC_SWAP=1 copies frame_idx when theta < previous theta (wrap); SYNC_SWAP=0 tracks frame_idx.
- Arbiter: ch_sel round-robins 0..CHANNELS-1, one channel per cycle, never stalls.
- Column c = (theta + theta_offset + c*TEX_WIDTH/CHANNELS) mod TEX_WIDTH (natural THETA_BITS wrap).
- Address = disp_idx*FRAME_SIZE + px_num[c]*TEX_WIDTH + col, FRAME_SIZE=TEX_WIDTH*LED_COUNT; px_num >= LED_COUNT clamped to LED_COUNT-1.
- Pipeline: px_num sampled edge k → rom_addr registered edge k → rom_data after edge k+ROM_LATENCY → pix_data[c] and pix_valid[c] at edge k+ROM_LATENCY+1. Channel tag shifts with data.
- Scale per 8-bit component: out = (in*(brightness+1))>>8; 255 exact passthrough, 0 yields 0.
- After reset deassert, first pix_valid appears ROM_LATENCY+1 cycles after first sample.

Decomposition:
- Package pov_pkg: FRAME_SIZE, PXW, FIDX_W, ROM_AW computations, mode encodings, 24-bit GRB pixel typedef, scale function.
- Sub-module pov_frame_sequencer: timer, advance logic, modes, direction, done.
- Top: arbiter, address pipeline, scaler, swap logic.

Test Plan:
- Loop, frame_period=4, play=1, NUM_FRAMES=3 → frame_idx 0,1,2,0 every 4 cycles; done=0.
- One-shot, play=0, five step pulses, NUM_FRAMES=3 → frame_idx 1,2,2,2,2; done=1 from reaching 2; step with play=1 no change.
- Ping-pong, NUM_FRAMES=3, frame_period=2 → 0,1,2,1,0,1 sequence.
- SYNC_SWAP=1, theta 60→63→0, frame_idx changes at theta=61 → addresses keep old frame until theta=0 sample, then disp_idx*3328 offset.
- CHANNELS=2, theta=5, offset=0, px_num={3,10}, ROM_LATENCY=1 → ch0 addr 3*64+5=197, ch1 10*64+37=677; pix_valid strobes alternate, 2 cycles after sample.
- brightness=127, rom_data=0xFF8000 → pix_data 0x7F4000; reset=0 mid-stream → all outputs 0 next edge, no stale pix_valid.
